vend_input_conditioner: RTL and testbench
=========================================

Name: vend_input_conditioner

Overview:
- Upstream stage of the vending-machine FSM. Turns the raw, asynchronous coin-slot switch and select pushbutton into clean single-cycle K (coin) and A (select) pulses.
- Synchronises, debounces and edge-detects each input.
- Guarantees K and A are never high in the same cycle; the FSM treats K=1, A=1 as an illegal combination.
- Provides an inhibit so the machine can ignore inputs, e.g. while a product is dispensing.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronised level must differ from the stable level before the stable level toggles. Legal range ≥ 2.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- coin_raw, input, 1: raw coin-slot switch, asynchronous, bouncy; 1 = coin present.
- sel_raw, input, 1: raw select pushbutton, asynchronous, bouncy; 1 = pressed.
- inhibit, input, 1: synchronous. 1 = discard new edges and clear any pending select.
- K, output, 1: registered one-cycle coin pulse to the FSM.
- A, output, 1: registered one-cycle select pulse to the FSM.
- coin_stable, output, 1: debounced coin level, for status LED.
- sel_stable, output, 1: debounced select level, for status LED.

Behaviour:
- **Reset.** reset_n low clears everything asynchronously: sync flops, debounce counters, stable levels, pending flag, K, A, coin_stable, sel_stable all 0. Release is synchronous to clk.
- **Synchroniser.** Each channel uses a 2-flop synchroniser; the second flop output is sync_x.
- **Debounce.** Per channel there is a counter of width $clog2(DEBOUNCE_CYCLES+1), plus a stable_x register.
  - sync_x == stable_x: counter cleared to 0.
  - sync_x != stable_x: counter increments.
  - When the counter is at DEBOUNCE_CYCLES-1 and the levels still differ, stable_x toggles and the counter clears.
  - The counter never wraps.
- **Edge detect.** rise_x = stable_x AND NOT stable_x_d, where stable_x_d is a 1-cycle delay. Only rising edges generate pulses; falling edges are silent.
- **Latency.** From the first clk edge that samples raw high, with raw held steady, K or A goes high on edge DEBOUNCE_CYCLES+3 (edge 7 for the default). The pulse is exactly 1 cycle wide.
- **Arbiter FSM.** Two states: IDLE and PEND_A.
  - IDLE, rise_coin only: K=1 next cycle.
  - IDLE, rise_sel only: A=1 next cycle.
  - IDLE, both in the same cycle: K=1 next cycle, go to PEND_A.
  - PEND_A: A=1 next cycle, return to IDLE. The pending select has priority over a new coin edge; that coin edge is held in a one-deep coin_pending bit and issued the following cycle.
  - Invariant: (K & A) == 0 in every cycle.
- **Inhibit.** While inhibit=1, rise_coin and rise_sel are discarded, not queued. PEND_A and coin_pending are cleared and the next-cycle K and A are forced to 0. Debounce and stable levels keep tracking, so a button still held when inhibit drops produces no pulse; a fresh press is required.
- **Reset mid-debounce.** Partial counts are lost. A raw input still high after reset_n release is treated as a new rising edge, with full latency from release.
- **Status outputs.** coin_stable and sel_stable equal stable_x, registered.

Optional Feature:
- Macro: VEND_COIN_COUNT_EN.
- When defined:
  - Adds output coin_count [7:0], a count of K pulses actually issued.
  - Saturates at 255 and never wraps.
  - Cleared by reset_n.
  - Updates on the same edge K is registered high, so it reads n+1 in the cycle K=1.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: reset_n=0 with coin_raw=sel_raw=1 → K=A=0, coin_stable=sel_stable=0 while held; after release with inputs held, K=1 on release edge 7 and A=1 on release edge 8, each for 1 cycle.
- Clean coin: coin_raw 0→1 at edge 0, held for 20 cycles → K=1 only at edge 7, A=0 throughout, coin_stable=1 from edge 6.
- Bounce rejection: coin_raw high 3 cycles, low 1, high 3, low → K never asserted, coin_stable stays 0.
- Simultaneous: coin_raw and sel_raw rise on the same edge → K=1 at edge 7, A=1 at edge 8, and K&A never 1 in any cycle.
- Inhibit: inhibit=1 from edge 0 to 10 while sel_raw rises at edge 0 and is held; inhibit drops at edge 10 → A never pulses. Release sel_raw, re-press: A pulses 7 edges after the re-press.
- VEND_COIN_COUNT_EN: 257 clean coin presses → coin_count reaches 255 and holds; reset_n low → coin_count=0 immediately.

Source files
------------

// File: rtl/vend_input_conditioner.sv
// vend_input_conditioner
//
// Front end of the vending-machine FSM. Takes the raw coin-slot switch and the
// select pushbutton, synchronises and debounces each one, detects rising edges
// and hands the FSM clean single-cycle K (coin) and A (select) pulses. K and A
// are never high in the same cycle. When a coin and a select arrive together,
// the coin goes first and the select follows one cycle later.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive differing cycles before a stable level toggles (>= 2)
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   coin_raw     raw coin switch (async, bouncy), 1 = coin present
//   sel_raw      raw select button (async, bouncy), 1 = pressed
//   inhibit      synchronous; 1 = drop new edges and clear any queued select/coin
//   K            registered one-cycle coin pulse
//   A            registered one-cycle select pulse
//   coin_stable  debounced coin level (status LED)
//   sel_stable   debounced select level (status LED)
//   coin_count   (only with VEND_COIN_COUNT_EN) saturating count of K pulses issued
//
// Optional feature macro: VEND_COIN_COUNT_EN
//
// Latency: raw sampled high on edge 0 -> stable toggles on edge DEBOUNCE_CYCLES+1,
// status level on +2, K/A on +3.

module vend_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       coin_raw,
    input  logic       sel_raw,
    input  logic       inhibit,
    output logic       K,
    output logic       A,
    output logic       coin_stable,
    output logic       sel_stable
`ifdef VEND_COIN_COUNT_EN
    ,
    output logic [7:0] coin_count
`endif
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    // Channel index 0 = coin, 1 = select.
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      stable_q;
    logic [1:0]      stable_dly_q;   // doubles as the registered status level
    logic [1:0]      rise_q;
    logic [CntW-1:0] cnt_q [2];

    typedef enum logic [0:0] {StIdle, StPendA} state_e;
    state_e state_q;
    logic   coin_pend_q;
    logic   k_issue;

    // Two-flop synchronisers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {sel_raw, coin_raw};
            sync2_q <= sync1_q;
        end
    end

    // Debounce: the stable level only follows the synchronised level after it
    // has disagreed for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CntMax) begin
                    stable_q[i] <= ~stable_q[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    // Delayed stable level and registered rising-edge strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_dly_q <= '0;
            rise_q       <= '0;
        end else begin
            stable_dly_q <= stable_q;
            rise_q       <= stable_q & ~stable_dly_q;
        end
    end

    assign coin_stable = stable_dly_q[0];
    assign sel_stable  = stable_dly_q[1];

    // A coin goes out next cycle when idle and either a fresh or a held coin exists.
    always_comb begin
        k_issue = 1'b0;
        if (!inhibit && state_q == StIdle) begin
            k_issue = coin_pend_q | rise_q[0];
        end
    end

    // Arbiter: coin wins a tie, the select is then owed for exactly one cycle.
    // A coin edge arriving while the select is owed waits in coin_pend_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            coin_pend_q <= 1'b0;
            K           <= 1'b0;
            A           <= 1'b0;
        end else begin
            K <= 1'b0;
            A <= 1'b0;
            if (inhibit) begin
                state_q     <= StIdle;
                coin_pend_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (k_issue) begin
                            K <= 1'b1;
                            // Fresh and held coin together: one issues, one stays held.
                            coin_pend_q <= coin_pend_q & rise_q[0];
                            if (rise_q[1]) begin
                                state_q <= StPendA;
                            end
                        end else if (rise_q[1]) begin
                            A <= 1'b1;
                        end
                    end
                    StPendA: begin
                        A       <= 1'b1;
                        state_q <= StIdle;
                        if (rise_q[0]) begin
                            coin_pend_q <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef VEND_COIN_COUNT_EN
    // Counts on the same edge that registers K high; saturates at 255.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            coin_count <= '0;
        end else if (k_issue && coin_count != 8'hFF) begin
            coin_count <= coin_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vend_input_conditioner.sv
// Testbench for vend_input_conditioner (DEBOUNCE_CYCLES = 4).
// Directed scenarios plus randomized stimulus, checked against a behavioural
// model that tracks sampled levels, run lengths and queued requests.

module tb_vend_input_conditioner;

    localparam int DEB = 4;

    logic clk = 1'b0;
    logic reset_n, coin_raw, sel_raw, inhibit;
    logic K, A, coin_stable, sel_stable;
`ifdef VEND_COIN_COUNT_EN
    logic [7:0] coin_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    vend_input_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .coin_raw    (coin_raw),
        .sel_raw     (sel_raw),
        .inhibit     (inhibit),
        .K           (K),
        .A           (A),
        .coin_stable (coin_stable),
        .sel_stable  (sel_stable)
`ifdef VEND_COIN_COUNT_EN
        ,
        .coin_count  (coin_count)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit h_c[$], h_s[$];       // raw values sampled on the last two edges
    int run_c, run_s;         // consecutive edges the synced level disagreed
    bit st_c, st_s;           // debounced levels
    int rise_c_at, rise_s_at; // edge number when each debounced level last rose
    int cyc = 0;
    bit sel_wait;
    int coin_pend;
    bit exp_k, exp_a, exp_cs, exp_ss;
    int exp_cnt;

    task automatic model_reset();
        h_c = {1'b0, 1'b0};
        h_s = {1'b0, 1'b0};
        run_c = 0; run_s = 0;
        st_c = 0; st_s = 0;
        rise_c_at = -100; rise_s_at = -100;
        sel_wait = 0; coin_pend = 0;
        exp_k = 0; exp_a = 0; exp_cs = 0; exp_ss = 0;
        exp_cnt = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        bit rq_c, rq_s;
        int coins;
        cyc++;
        // A debounced rise becomes an arbiter request two edges later.
        rq_c = (cyc == rise_c_at + 2);
        rq_s = (cyc == rise_s_at + 2);
        exp_k = 0;
        exp_a = 0;
        if (inhibit) begin
            sel_wait = 0;
            coin_pend = 0;
        end else if (sel_wait) begin
            exp_a = 1;
            sel_wait = 0;
            if (rq_c) coin_pend = 1;
        end else begin
            coins = coin_pend + int'(rq_c);
            if (coins > 0) begin
                exp_k = 1;
                coin_pend = (coins > 1) ? 1 : 0;
                if (rq_s) sel_wait = 1;
            end else if (rq_s) begin
                exp_a = 1;
            end
        end
        if (exp_k && exp_cnt < 255) exp_cnt++;
        exp_cs = st_c;
        exp_ss = st_s;
        if (h_c[0] != st_c) begin
            run_c++;
            if (run_c == DEB) begin
                st_c = ~st_c;
                run_c = 0;
                if (st_c) rise_c_at = cyc;
            end
        end else begin
            run_c = 0;
        end
        if (h_s[0] != st_s) begin
            run_s++;
            if (run_s == DEB) begin
                st_s = ~st_s;
                run_s = 0;
                if (st_s) rise_s_at = cyc;
            end
        end else begin
            run_s = 0;
        end
        h_c.push_back(coin_raw);
        void'(h_c.pop_front());
        h_s.push_back(sel_raw);
        void'(h_s.pop_front());
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0; coin_raw = 1'b1; sel_raw = 1'b1; inhibit = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({K, A, coin_stable, sel_stable} !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_hold %0d: KA/stable=%b want 0000", i,
                         {K, A, coin_stable, sel_stable});
            end
            @(posedge clk);
            #1;
        end
        reset_n = 1'b1;
        for (int k = 0; k < 14; k++) begin
            tick();
            vectors++;
            if ({K, A, coin_stable, sel_stable} !== {exp_k, exp_a, exp_cs, exp_ss}) begin
                miscompares++;
                $display("FAIL reset_release edge %0d: got %b want %b", k,
                         {K, A, coin_stable, sel_stable}, {exp_k, exp_a, exp_cs, exp_ss});
            end
            vectors++;
            if ({K, A} !== {k == 7, k == 8}) begin
                miscompares++;
                $display("FAIL reset_latency edge %0d: KA=%b want %b", k, {K, A},
                         {k == 7, k == 8});
            end
        end
        coin_raw = 1'b0; sel_raw = 1'b0;
        settle(12);
    endtask

    task automatic test_clean_coin();
        coin_raw = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            vectors++;
            if ({K, A, coin_stable} !== {k == 7, 1'b0, k >= 6}) begin
                miscompares++;
                $display("FAIL clean_coin edge %0d: K,A,coin_stable=%b want %b", k,
                         {K, A, coin_stable}, {k == 7, 1'b0, k >= 6});
            end
            vectors++;
            if ({K, A, coin_stable, sel_stable} !== {exp_k, exp_a, exp_cs, exp_ss}) begin
                miscompares++;
                $display("FAIL clean_coin_model edge %0d: got %b want %b", k,
                         {K, A, coin_stable, sel_stable}, {exp_k, exp_a, exp_cs, exp_ss});
            end
        end
        coin_raw = 1'b0;
        settle(12);
    endtask

    task automatic test_bounce();
        logic [17:0] pat;
        pat = 18'b000000000001110111; // bit k drives edge k
        for (int k = 0; k < 18; k++) begin
            coin_raw = pat[k];
            tick();
            vectors++;
            if ({K, coin_stable} !== 2'b00) begin
                miscompares++;
                $display("FAIL bounce edge %0d: K,coin_stable=%b want 00", k, {K, coin_stable});
            end
            vectors++;
            if ({K, A, coin_stable, sel_stable} !== {exp_k, exp_a, exp_cs, exp_ss}) begin
                miscompares++;
                $display("FAIL bounce_model edge %0d: got %b want %b", k,
                         {K, A, coin_stable, sel_stable}, {exp_k, exp_a, exp_cs, exp_ss});
            end
        end
        settle(4);
    endtask

    task automatic test_simultaneous();
        coin_raw = 1'b1; sel_raw = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            vectors++;
            if ({K, A} !== {k == 7, k == 8}) begin
                miscompares++;
                $display("FAIL simultaneous edge %0d: KA=%b want %b", k, {K, A},
                         {k == 7, k == 8});
            end
            vectors++;
            if ((K & A) !== 1'b0) begin
                miscompares++;
                $display("FAIL k_and_a edge %0d: K&A=%b want 0", k, K & A);
            end
        end
        coin_raw = 1'b0; sel_raw = 1'b0;
        settle(12);
    endtask

    task automatic test_inhibit();
        inhibit = 1'b1; sel_raw = 1'b1;
        for (int k = 0; k < 25; k++) begin
            if (k == 10) inhibit = 1'b0;
            tick();
            vectors++;
            if ({A, K} !== 2'b00) begin
                miscompares++;
                $display("FAIL inhibit_held edge %0d: A,K=%b want 00", k, {A, K});
            end
        end
        sel_raw = 1'b0;
        settle(12);
        sel_raw = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            vectors++;
            if ({A, K} !== {k == 7, 1'b0}) begin
                miscompares++;
                $display("FAIL inhibit_repress edge %0d: A,K=%b want %b", k, {A, K},
                         {k == 7, 1'b0});
            end
        end
        sel_raw = 1'b0;
        settle(12);
    endtask

    task automatic test_random();
        int hold;
        for (int seg = 0; seg < 400; seg++) begin
            coin_raw = 1'($urandom_range(0, 1));
            sel_raw  = 1'($urandom_range(0, 1));
            inhibit  = ($urandom_range(0, 9) == 0);
            hold     = $urandom_range(1, 12);
            for (int j = 0; j < hold; j++) begin
                tick();
                vectors++;
                if ({K, A, coin_stable, sel_stable} !== {exp_k, exp_a, exp_cs, exp_ss}) begin
                    miscompares++;
                    $display("FAIL random seg %0d cyc %0d: got %b want %b", seg, cyc,
                             {K, A, coin_stable, sel_stable}, {exp_k, exp_a, exp_cs, exp_ss});
                end
                if ((K & A) !== 1'b0) begin
                    miscompares++;
                    $display("FAIL random_k_and_a cyc %0d: K&A=%b want 0", cyc, K & A);
                end
`ifdef VEND_COIN_COUNT_EN
                vectors++;
                if (coin_count !== 8'(exp_cnt)) begin
                    miscompares++;
                    $display("FAIL random_count cyc %0d: got %0d want %0d", cyc, coin_count,
                             exp_cnt);
                end
`endif
            end
        end
        coin_raw = 1'b0; sel_raw = 1'b0; inhibit = 1'b0;
        settle(12);
    endtask

`ifdef VEND_COIN_COUNT_EN
    task automatic test_coin_count();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        model_reset();
        for (int p = 0; p < 257; p++) begin
            for (int j = 0; j < 17; j++) begin
                coin_raw = (j < 8);
                tick();
                vectors++;
                if (coin_count !== 8'(exp_cnt)) begin
                    miscompares++;
                    $display("FAIL coin_count press %0d step %0d: got %0d want %0d", p, j,
                             coin_count, exp_cnt);
                end
            end
        end
        vectors++;
        if (coin_count !== 8'd255) begin
            miscompares++;
            $display("FAIL coin_count_sat: got %0d want 255", coin_count);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (coin_count !== 8'd0) begin
            miscompares++;
            $display("FAIL coin_count_reset: got %0d want 0", coin_count);
        end
        #2;
        reset_n = 1'b1;
        model_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_clean_coin();
        test_bounce();
        test_simultaneous();
        test_inhibit();
        test_random();
`ifdef VEND_COIN_COUNT_EN
        test_coin_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
